braille_quiz_ctrl: RTL and testbench

Trainer sequencer that consumes the 2-second tick (timeout2s) from the second-counter stage. It steps through braille letters and shows each dot pattern on six LEDs for a fixed number of ticks. It then blanks the LEDs, waits for the learner to key in the pattern on switches and press submit, and scores the answer. It sits between the timing chain and the LED/score display logic.

---
 rtl/braille_quiz_ctrl_pkg.sv | 19 +
 rtl/braille_quiz_ctrl_rom.sv | 44 ++++
 rtl/braille_quiz_ctrl.sv | 153 +++++++++++++++
 tb/tb_braille_quiz_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/braille_quiz_ctrl_pkg.sv
// Shared definitions for the braille trainer: state encoding, dot ordering
// and a helper that turns a braille dot number into its LED bit.
package braille_quiz_ctrl_pkg;

  localparam int DOTS_W   = 6;
  localparam int IDX_W    = 5;
  localparam int DOT1_BIT = 0;  // bit i carries braille dot i+1

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHOW     = 3'd1;
  localparam logic [2:0] ST_ANSWER   = 3'd2;
  localparam logic [2:0] ST_FEEDBACK = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  function automatic logic [DOTS_W-1:0] dot(input int n);
    return DOTS_W'(1) << (DOT1_BIT + n - 1);
  endfunction

endpackage

// File: rtl/braille_quiz_ctrl_rom.sv
// Grade-1 braille letter ROM: index 0..25 (a..z) to six-dot pattern.
// Out-of-range indices return a blank cell.
module braille_rom
  import braille_quiz_ctrl_pkg::*;
(
  input  logic [IDX_W-1:0]  index,
  output logic [DOTS_W-1:0] dots
);

  always_comb begin
    dots = '0;
    case (index)
      5'd0:  dots = dot(1);
      5'd1:  dots = dot(1) | dot(2);
      5'd2:  dots = dot(1) | dot(4);
      5'd3:  dots = dot(1) | dot(4) | dot(5);
      5'd4:  dots = dot(1) | dot(5);
      5'd5:  dots = dot(1) | dot(2) | dot(4);
      5'd6:  dots = dot(1) | dot(2) | dot(4) | dot(5);
      5'd7:  dots = dot(1) | dot(2) | dot(5);
      5'd8:  dots = dot(2) | dot(4);
      5'd9:  dots = dot(2) | dot(4) | dot(5);
      // k..t repeat a..j with dot 3 added
      5'd10: dots = dot(1) | dot(3);
      5'd11: dots = dot(1) | dot(2) | dot(3);
      5'd12: dots = dot(1) | dot(3) | dot(4);
      5'd13: dots = dot(1) | dot(3) | dot(4) | dot(5);
      5'd14: dots = dot(1) | dot(3) | dot(5);
      5'd15: dots = dot(1) | dot(2) | dot(3) | dot(4);
      5'd16: dots = dot(1) | dot(2) | dot(3) | dot(4) | dot(5);
      5'd17: dots = dot(1) | dot(2) | dot(3) | dot(5);
      5'd18: dots = dot(2) | dot(3) | dot(4);
      5'd19: dots = dot(2) | dot(3) | dot(4) | dot(5);
      5'd20: dots = dot(1) | dot(3) | dot(6);
      5'd21: dots = dot(1) | dot(2) | dot(3) | dot(6);
      5'd22: dots = dot(2) | dot(4) | dot(5) | dot(6);
      5'd23: dots = dot(1) | dot(3) | dot(4) | dot(6);
      5'd24: dots = dot(1) | dot(3) | dot(4) | dot(5) | dot(6);
      5'd25: dots = dot(1) | dot(3) | dot(5) | dot(6);
      default: dots = '0;
    endcase
  end

endmodule

// File: rtl/braille_quiz_ctrl.sv
// Braille trainer sequencer: show a letter, blank, collect and score the
// learner's answer, show feedback, advance. Paced by the 2 s tick.
module braille_quiz_ctrl
  import braille_quiz_ctrl_pkg::*;
#(
  parameter int NUM_CHARS    = 26,
  parameter int SHOW_TICKS   = 2,
  parameter int ANSWER_TICKS = 5,
  parameter int FB_TICKS     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              timeout2s,
  input  logic              start,
  input  logic              submit,
  input  logic [DOTS_W-1:0] user_dots,
  output logic [DOTS_W-1:0] disp_dots,
  output logic [IDX_W-1:0]  char_idx,
  output logic [IDX_W-1:0]  score,
  output logic              correct,
  output logic              wrong,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0]       LIM_SHOW = 3'(SHOW_TICKS - 1);
  localparam logic [2:0]       LIM_ANS  = 3'(ANSWER_TICKS - 1);
  localparam logic [2:0]       LIM_FB   = 3'(FB_TICKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);
  localparam logic [IDX_W-1:0] MAX_SCR  = IDX_W'(NUM_CHARS);

  logic [2:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  char_idx_q, char_idx_d;
  logic [IDX_W-1:0]  score_q, score_d;
  logic              correct_q, correct_d;
  logic              wrong_q, wrong_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DOTS_W-1:0] disp_dots_q, disp_dots_d;
  logic [DOTS_W-1:0] cur_dots, nxt_dots;

  // cur_dots scores the answer; nxt_dots feeds the registered LED pattern
  braille_rom u_rom_cur (.index(char_idx_q), .dots(cur_dots));
  braille_rom u_rom_nxt (.index(char_idx_d), .dots(nxt_dots));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    char_idx_d = char_idx_q;
    score_d    = score_q;
    correct_d  = correct_q;
    wrong_d    = wrong_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_SHOW;
          cnt_d      = '0;
          char_idx_d = '0;
          score_d    = '0;
        end
      end
      ST_SHOW: begin
        if (timeout2s) begin
          if (cnt_q == LIM_SHOW) begin
            state_d = ST_ANSWER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_ANSWER: begin
        // a submit on the final tick still gets scored on its merits
        if (submit) begin
          state_d = ST_FEEDBACK;
          cnt_d   = '0;
          if (user_dots == cur_dots) begin
            correct_d = 1'b1;
            if (score_q < MAX_SCR) score_d = score_q + 5'd1;
          end else begin
            wrong_d = 1'b1;
          end
        end else if (timeout2s) begin
          if (cnt_q == LIM_ANS) begin
            state_d = ST_FEEDBACK;
            cnt_d   = '0;
            wrong_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_FEEDBACK: begin
        if (timeout2s) begin
          if (cnt_q == LIM_FB) begin
            cnt_d     = '0;
            correct_d = 1'b0;
            wrong_d   = 1'b0;
            if (char_idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_SHOW;
              char_idx_d = char_idx_q + 5'd1;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    disp_dots_d = (state_d == ST_SHOW || state_d == ST_FEEDBACK) ? nxt_dots : '0;
    busy_d      = (state_d == ST_SHOW || state_d == ST_ANSWER || state_d == ST_FEEDBACK);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      char_idx_q  <= '0;
      score_q     <= '0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      disp_dots_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      char_idx_q  <= char_idx_d;
      score_q     <= score_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      disp_dots_q <= disp_dots_d;
    end
  end

  assign disp_dots = disp_dots_q;
  assign char_idx  = char_idx_q;
  assign score     = score_q;
  assign correct   = correct_q;
  assign wrong     = wrong_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_braille_quiz_ctrl.sv
// Bench for braille_quiz_ctrl: directed sessions, a countdown-based
// behavioural model checked every cycle, plus literal spot checks.
module tb_braille_quiz_ctrl;

  localparam int N      = 3;
  localparam int SHOW_T = 2;
  localparam int ANS_T  = 5;
  localparam int FB_T   = 1;

  localparam int P_IDLE = 0, P_SHOW = 1, P_ANS = 2, P_FB = 3, P_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       timeout2s = 1'b0;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic [5:0] user_dots = 6'd0;
  logic [5:0] disp_dots;
  logic [4:0] char_idx;
  logic [4:0] score;
  logic       correct, wrong, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  braille_quiz_ctrl #(
    .NUM_CHARS(N), .SHOW_TICKS(SHOW_T), .ANSWER_TICKS(ANS_T), .FB_TICKS(FB_T)
  ) dut (
    .clk(clk), .rst(rst), .timeout2s(timeout2s), .start(start), .submit(submit),
    .user_dots(user_dots), .disp_dots(disp_dots), .char_idx(char_idx), .score(score),
    .correct(correct), .wrong(wrong), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Letters written as the dot numbers a reader of braille would name.
  string BR[26] = '{"1", "12", "14", "145", "15", "124", "1245", "125", "24", "245",
                    "13", "123", "134", "1345", "135", "1234", "12345", "1235", "234", "2345",
                    "136", "1236", "2456", "1346", "13456", "1356"};

  function automatic logic [5:0] pat(input int idx);
    logic [5:0] p;
    string s;
    p = 6'd0;
    if (idx >= 0 && idx < 26) begin
      s = BR[idx];
      for (int k = 0; k < s.len(); k++) p[int'(s[k]) - 49] = 1'b1;
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus ticks remaining before the phase ends.
  int m_phase = P_IDLE;
  int m_left  = 0;
  int m_idx   = 0;
  int m_score = 0;
  bit m_ok    = 1'b0;
  bit m_bad   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= P_IDLE; m_left <= 0; m_idx <= 0; m_score <= 0; m_ok <= 1'b0; m_bad <= 1'b0;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE:
          if (start) begin
            m_phase <= P_SHOW; m_left <= SHOW_T; m_idx <= 0; m_score <= 0;
          end
        P_SHOW:
          if (timeout2s) begin
            if (m_left == 1) begin m_phase <= P_ANS; m_left <= ANS_T; end
            else m_left <= m_left - 1;
          end
        P_ANS:
          if (submit) begin
            m_phase <= P_FB; m_left <= FB_T;
            if (user_dots == pat(m_idx)) begin
              m_ok <= 1'b1;
              m_score <= (m_score < N) ? m_score + 1 : m_score;
            end else m_bad <= 1'b1;
          end else if (timeout2s) begin
            if (m_left == 1) begin m_phase <= P_FB; m_left <= FB_T; m_bad <= 1'b1; end
            else m_left <= m_left - 1;
          end
        P_FB:
          if (timeout2s) begin
            if (m_left == 1) begin
              m_ok <= 1'b0; m_bad <= 1'b0;
              if (m_idx == N - 1) m_phase <= P_DONE;
              else begin m_idx <= m_idx + 1; m_phase <= P_SHOW; m_left <= SHOW_T; end
            end else m_left <= m_left - 1;
          end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    check("m_disp", 32'(disp_dots),
          32'((m_phase == P_SHOW || m_phase == P_FB) ? pat(m_idx) : 6'd0));
    check("m_idx", 32'(char_idx), 32'(m_idx));
    check("m_score", 32'(score), 32'(m_score));
    check("m_correct", 32'(correct), 32'(m_ok));
    check("m_wrong", 32'(wrong), 32'(m_bad));
    check("m_busy", 32'(busy), 32'(m_phase == P_SHOW || m_phase == P_ANS || m_phase == P_FB));
    check("m_done", 32'(done), 32'(m_phase == P_DONE));
  end

  task automatic cyc(input bit t, input bit st, input bit sb, input logic [5:0] u);
    timeout2s = t; start = st; submit = sb; user_dots = u;
    @(negedge clk);
    timeout2s = 1'b0; start = 1'b0; submit = 1'b0;
  endtask

  task automatic tick(); cyc(1'b1, 1'b0, 1'b0, 6'd0); endtask
  task automatic idle(input int n); repeat (n) @(negedge clk); endtask

  logic [5:0] lit_pat [3] = '{6'b000001, 6'b000011, 6'b001001};

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    rst = 1'b0;
    check("rst_disp", 32'(disp_dots), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_score", 32'(score), 0);

    // Session 1: correct, wrong, then submit on the final answer tick
    cyc(0, 1, 0, 6'd0);
    check("s1_show_disp", 32'(disp_dots), 32'(6'b000001));
    check("s1_show_busy", 32'(busy), 1);
    cyc(0, 1, 0, 6'd0);
    cyc(0, 0, 1, 6'b000001);
    check("ign_disp", 32'(disp_dots), 32'(6'b000001));
    check("ign_score", 32'(score), 0);
    check("ign_correct", 32'(correct), 0);
    idle(3);
    tick();
    check("show_hold", 32'(disp_dots), 32'(6'b000001));
    idle(2);
    tick();
    check("ans_blank", 32'(disp_dots), 0);
    cyc(0, 0, 1, 6'b000001);
    check("a_correct", 32'(correct), 1);
    check("a_score", 32'(score), 1);
    check("a_fb_disp", 32'(disp_dots), 32'(6'b000001));
    cyc(0, 0, 1, 6'b111111);
    check("fb_ign_correct", 32'(correct), 1);
    check("fb_ign_score", 32'(score), 1);
    tick();
    check("b_idx", 32'(char_idx), 1);
    check("b_disp", 32'(disp_dots), 32'(6'b000011));
    check("b_correct_clr", 32'(correct), 0);
    tick(); tick();
    cyc(0, 0, 1, 6'b000001);
    check("b_wrong", 32'(wrong), 1);
    check("b_score", 32'(score), 1);
    check("b_fb_disp", 32'(disp_dots), 32'(6'b000011));
    tick();
    check("c_disp", 32'(disp_dots), 32'(6'b001001));
    tick(); tick();
    for (int i = 0; i < 4; i++) begin tick(); idle(1); end
    check("c_wait_wrong", 32'(wrong), 0);
    check("c_wait_busy", 32'(busy), 1);
    cyc(1, 0, 1, 6'b001001);
    check("c_race_correct", 32'(correct), 1);
    check("c_race_score", 32'(score), 2);
    tick();
    check("s1_done", 32'(done), 1);
    check("s1_idx", 32'(char_idx), 2);
    check("s1_busy", 32'(busy), 0);
    cyc(0, 0, 1, 6'b001001);
    check("done_ign_score", 32'(score), 2);

    // Session 2: all three correct
    cyc(0, 1, 0, 6'd0);
    check("s2_idx", 32'(char_idx), 0);
    check("s2_score", 32'(score), 0);
    check("s2_disp", 32'(disp_dots), 32'(6'b000001));
    for (int k = 0; k < 3; k++) begin
      tick(); tick();
      cyc(0, 0, 1, lit_pat[k]);
      tick();
    end
    check("s2_done", 32'(done), 1);
    check("s2_score_end", 32'(score), 3);
    check("s2_idx_end", 32'(char_idx), 2);
    check("s2_busy", 32'(busy), 0);

    // Session 3: pure timeout, then reset mid-ANSWER
    cyc(0, 1, 0, 6'd0);
    tick(); tick();
    for (int i = 0; i < 5; i++) tick();
    check("to_wrong", 32'(wrong), 1);
    check("to_correct", 32'(correct), 0);
    check("to_score", 32'(score), 0);
    tick();
    tick(); tick();
    check("pre_rst_idx", 32'(char_idx), 1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_idx", 32'(char_idx), 0);
    tick();
    cyc(0, 0, 1, 6'b000011);
    tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_disp", 32'(disp_dots), 0);
    check("post_rst_wrong", 32'(wrong), 0);
    check("post_rst_correct", 32'(correct), 0);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
